// File: rtl/countdown_ctrl.sv
// countdown_ctrl: sequencer for a 2-digit BCD countdown.
// Holds the preset and the working count, and decodes one-pulse buttons
// into IDLE/SET/RUN/PAUSE/DONE. It drives the alarm LED blink pattern.
module countdown_ctrl #(
  parameter logic [3:0] INIT_TENS = 4'd3,
  parameter logic [3:0] INIT_ONES = 4'd0
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        tick,
  input  logic        btn_start,
  input  logic        btn_set,
  input  logic        btn_inc,
  output logic [3:0]  digit1,
  output logic [3:0]  digit0,
  output logic        count_en,
  output logic        done,
  output logic [2:0]  state,
  output logic [15:0] led
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SET   = 3'd1,
    S_RUN   = 3'd2,
    S_PAUSE = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  pre_t_q, pre_o_q, pre_t_d, pre_o_d;
  logic [3:0]  cnt_t_q, cnt_o_q, cnt_t_d, cnt_o_d;
  logic [15:0] led_q, led_d;

  logic [3:0]  inc_t, inc_o, dec_t, dec_o;
  logic        cnt_zero, dec_zero;

  // BCD increment of the preset (99 wraps to 00) and decrement of the count
  always_comb begin
    inc_t = pre_t_q;
    inc_o = pre_o_q + 4'd1;
    if (pre_o_q == 4'd9) begin
      inc_o = 4'd0;
      inc_t = (pre_t_q == 4'd9) ? 4'd0 : pre_t_q + 4'd1;
    end
    dec_t = cnt_t_q;
    dec_o = cnt_o_q - 4'd1;
    if (cnt_o_q == 4'd0) begin
      dec_o = 4'd9;
      dec_t = cnt_t_q - 4'd1;
    end
    cnt_zero = (cnt_t_q == 4'd0) && (cnt_o_q == 4'd0);
    // the result is 00 exactly when the count is 01
    dec_zero = (cnt_t_q == 4'd0) && (cnt_o_q == 4'd1);
  end

  // Next-state, preset, count and LED logic
  always_comb begin
    state_d = state_q;
    pre_t_d = pre_t_q;
    pre_o_d = pre_o_q;
    cnt_t_d = cnt_t_q;
    cnt_o_d = cnt_o_q;
    led_d   = '0;
    case (state_q)
      S_IDLE: begin
        if (btn_start) begin
          if (cnt_zero) begin
            state_d = S_DONE;
            led_d   = 16'hFFFF;
          end else begin
            state_d = S_RUN;
          end
        end else if (btn_set) begin
          state_d = S_SET;
        end
      end
      S_SET: begin
        if (btn_inc) begin
          pre_t_d = inc_t;
          pre_o_d = inc_o;
        end
        if (btn_set) begin
          // load whatever the preset becomes on this edge
          cnt_t_d = btn_inc ? inc_t : pre_t_q;
          cnt_o_d = btn_inc ? inc_o : pre_o_q;
          state_d = S_IDLE;
        end
      end
      S_RUN: begin
        if (tick && !cnt_zero) begin
          cnt_t_d = dec_t;
          cnt_o_d = dec_o;
        end
        // reaching 00 beats a simultaneous pause; 00 in RUN is a safety catch
        if (cnt_zero || (tick && dec_zero)) begin
          state_d = S_DONE;
          led_d   = 16'hFFFF;
        end else if (btn_start) begin
          state_d = S_PAUSE;
        end
      end
      S_PAUSE: begin
        if (btn_start) begin
          state_d = S_RUN;
        end else if (btn_set) begin
          state_d = S_IDLE;
          cnt_t_d = pre_t_q;
          cnt_o_d = pre_o_q;
        end
      end
      S_DONE: begin
        if (btn_start || btn_set) begin
          state_d = S_IDLE;
          cnt_t_d = pre_t_q;
          cnt_o_d = pre_o_q;
        end else begin
          led_d = tick ? ~led_q : led_q;
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_t_d = pre_t_q;
        cnt_o_d = pre_o_q;
      end
    endcase
  end

  // State registers with asynchronous reset
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= S_IDLE;
      pre_t_q <= INIT_TENS;
      pre_o_q <= INIT_ONES;
      cnt_t_q <= INIT_TENS;
      cnt_o_q <= INIT_ONES;
      led_q   <= '0;
    end else begin
      state_q <= state_d;
      pre_t_q <= pre_t_d;
      pre_o_q <= pre_o_d;
      cnt_t_q <= cnt_t_d;
      cnt_o_q <= cnt_o_d;
      led_q   <= led_d;
    end
  end

  assign digit1   = (state_q == S_SET) ? pre_t_q : cnt_t_q;
  assign digit0   = (state_q == S_SET) ? pre_o_q : cnt_o_q;
  assign count_en = (state_q == S_RUN);
  assign done     = (state_q == S_DONE);
  assign state    = state_q;
  assign led      = led_q;

endmodule
